// File: rtl/ysyx_220053_pkg.sv
// ysyx_220053 shared definitions: datapath width, ALU op codes, next-PC
// select codes, ALU operand-B select codes and load/store size codes.
// No ports; imported by ysyx_220053_alu and ysyx_220053_exu.
package ysyx_220053_pkg;

  localparam int XLEN    = 64;
  localparam int NR_REGS = 32;

  // ALU operation codes
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_COPYB  = 5'd10;
  localparam logic [4:0] ALU_MUL    = 5'd11;
  localparam logic [4:0] ALU_MULH   = 5'd12;
  localparam logic [4:0] ALU_MULHSU = 5'd13;
  localparam logic [4:0] ALU_MULHU  = 5'd14;
  localparam logic [4:0] ALU_DIV    = 5'd15;
  localparam logic [4:0] ALU_DIVU   = 5'd16;
  localparam logic [4:0] ALU_REM    = 5'd17;
  localparam logic [4:0] ALU_REMU   = 5'd18;

  // Next-PC select codes
  localparam logic [2:0] BR_SNPC = 3'b000;
  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam logic [2:0] BR_EQZ  = 3'b011;  // taken when ALU result == 0
  localparam logic [2:0] BR_NEZ  = 3'b100;  // taken when ALU result != 0

  // ALU operand-B select codes
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] SRCB_ZERO = 2'b11;

  // Load/store size and sign codes (funct3 encoding)
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_D  = 3'b011;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;
  localparam logic [2:0] MEM_WU = 3'b110;

endpackage

// File: rtl/ysyx_220053_alu.sv
// ysyx_220053 integer ALU, purely combinational (zero latency, no handshake).
// Ports: a_i/b_i operands, alu_op_i operation, word_i 32-bit (W) mode -> result_o.
// Macro YSYX_220053_RV64M_EN enables ALUOp 11-18 (mul/div); otherwise they yield 0.
module ysyx_220053_alu
  import ysyx_220053_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      alu_op_i,
  input  logic            word_i,
  output logic [XLEN-1:0] result_o
);

  // In word mode the operands are re-extended from bit 31 so that the 64-bit
  // datapath produces correct 32-bit results in its low half: signed ops see
  // the sign-extended view, unsigned ops the zero-extended view.
  logic [XLEN-1:0] a_s, b_s, a_u, b_u;
  logic [5:0]      shamt;
  logic [XLEN-1:0] r;

  always_comb begin
    a_s   = a_i;
    b_s   = b_i;
    a_u   = a_i;
    b_u   = b_i;
    shamt = b_i[5:0];
    if (word_i) begin
      a_s   = {{32{a_i[31]}}, a_i[31:0]};
      b_s   = {{32{b_i[31]}}, b_i[31:0]};
      a_u   = {32'b0, a_i[31:0]};
      b_u   = {32'b0, b_i[31:0]};
      shamt = {1'b0, b_i[4:0]};
    end
  end

`ifdef YSYX_220053_RV64M_EN
  // One shared 128-bit multiplier; operand extension picks the signedness.
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN-1:0]   quot_s, rem_s, quot_u, rem_u;

  always_comb begin
    mul_a = {64'b0, a_u};
    mul_b = {64'b0, b_u};
    if (alu_op_i == ALU_MULH || alu_op_i == ALU_MULHSU) begin
      mul_a = {{64{a_s[63]}}, a_s};
    end
    if (alu_op_i == ALU_MULH) begin
      mul_b = {{64{b_s[63]}}, b_s};
    end
  end

  assign prod = mul_a * mul_b;

  // Divide-by-zero and overflow are handled explicitly. Word-mode overflow
  // (-2^31 / -1) cannot overflow at 64 bits and falls out of the plain path.
  always_comb begin
    if (b_s == '0) begin
      quot_s = '1;
      rem_s  = a_s;
    end else if (a_s == {1'b1, 63'b0} && b_s == '1) begin
      quot_s = a_s;
      rem_s  = '0;
    end else begin
      quot_s = $signed(a_s) / $signed(b_s);
      rem_s  = $signed(a_s) % $signed(b_s);
    end
    if (b_u == '0) begin
      quot_u = '1;
      rem_u  = a_u;
    end else begin
      quot_u = a_u / b_u;
      rem_u  = a_u % b_u;
    end
  end
`endif

  always_comb begin
    r = '0;
    case (alu_op_i)
      ALU_ADD:   r = a_u + b_u;
      ALU_SUB:   r = a_u - b_u;
      ALU_SLL:   r = a_u << shamt;
      ALU_SLT:   r = {63'b0, $signed(a_s) < $signed(b_s)};
      ALU_SLTU:  r = {63'b0, a_u < b_u};
      ALU_XOR:   r = a_u ^ b_u;
      ALU_SRL:   r = a_u >> shamt;
      ALU_SRA:   r = $unsigned($signed(a_s) >>> shamt);
      ALU_OR:    r = a_u | b_u;
      ALU_AND:   r = a_u & b_u;
      ALU_COPYB: r = b_u;
`ifdef YSYX_220053_RV64M_EN
      ALU_MUL:   r = prod[63:0];
      // High half of a 32x32 product sits in bits 63:32.
      ALU_MULH, ALU_MULHSU, ALU_MULHU:
                 r = word_i ? {32'b0, prod[63:32]} : prod[127:64];
      ALU_DIV:   r = quot_s;
      ALU_DIVU:  r = quot_u;
      ALU_REM:   r = rem_s;
      ALU_REMU:  r = rem_u;
`else
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU:
                 r = '0;
`endif
      default:   r = '0;
    endcase
  end

  assign result_o = word_i ? {{32{r[31]}}, r[31:0]} : r;

endmodule

// File: rtl/ysyx_220053_exu.sv
// ysyx_220053 single-cycle execute/writeback: regfile, ALU, next PC, load/store alignment.
// Latency: dnpc/memory/writeback combinational, state commits on clk; no backpressure.
// Ports: clk/rst, decode controls (rd,rs1,rs2,wen,ALUSrcA/B,ALUOp,Branch,MemOp,MemToReg,
//        MemWen,MulOp), pc/imm in, dnpc out, mem_* data-memory interface.
// Macro YSYX_220053_RV64M_EN (see ysyx_220053_alu) enables the M-extension ops.
module ysyx_220053_exu
  import ysyx_220053_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic            wen,
  input  logic            ALUSrcA,
  input  logic [1:0]      ALUSrcB,
  input  logic [4:0]      ALUOp,
  input  logic [2:0]      Branch,
  input  logic [2:0]      MemOp,
  input  logic            MemToReg,
  input  logic            MemWen,
  input  logic [1:0]      MulOp,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] dnpc,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_ren,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask
);

  logic [XLEN-1:0] regs_q [NR_REGS];
  logic [XLEN-1:0] rf_wdata_d;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] op_a, op_b, alu_res;
  logic [XLEN-1:0] snpc, br_tgt, jalr_sum;
  logic [2:0]      byte_off;
  logic [XLEN-1:0] ld_shift, ld_data;
  logic [7:0]      base_mask;
  logic            unused_mulop;

  // MulOp[1] is reserved.
  assign unused_mulop = MulOp[1];

  // Register file: combinational reads, x0 hardwired to zero.
  assign rs1_val = (rs1 == 5'd0) ? '0 : regs_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs_q[rs2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wen && rd != 5'd0) begin
      regs_q[rd] <= rf_wdata_d;
    end
  end

  // Operand selection
  assign op_a = ALUSrcA ? pc : rs1_val;

  always_comb begin
    op_b = '0;
    case (ALUSrcB)
      SRCB_RS2:  op_b = rs2_val;
      SRCB_IMM:  op_b = imm;
      SRCB_FOUR: op_b = 64'd4;
      SRCB_ZERO: op_b = '0;
      default:   op_b = '0;
    endcase
  end

  ysyx_220053_alu u_alu (
    .a_i      (op_a),
    .b_i      (op_b),
    .alu_op_i (ALUOp),
    .word_i   (MulOp[0]),
    .result_o (alu_res)
  );

  // Next PC; JALR has its own adder so the ALU stays free for the link value.
  assign snpc     = pc + 64'd4;
  assign br_tgt   = pc + imm;
  assign jalr_sum = rs1_val + imm;

  always_comb begin
    dnpc = snpc;
    case (Branch)
      BR_SNPC: dnpc = snpc;
      BR_JAL:  dnpc = br_tgt;
      BR_JALR: dnpc = {jalr_sum[63:1], 1'b0};
      BR_EQZ:  dnpc = (alu_res == '0) ? br_tgt : snpc;
      BR_NEZ:  dnpc = (alu_res != '0) ? br_tgt : snpc;
      default: dnpc = snpc;
    endcase
  end

  // Memory interface; lanes past the doubleword boundary are simply dropped.
  assign byte_off = alu_res[2:0];
  assign mem_addr = {alu_res[63:3], 3'b000};
  assign mem_ren  = MemToReg;
  assign mem_wen  = MemWen & ~rst;

  assign ld_shift = mem_rdata >> {byte_off, 3'b000};

  always_comb begin
    ld_data = ld_shift;
    case (MemOp)
      MEM_B:   ld_data = {{56{ld_shift[7]}},  ld_shift[7:0]};
      MEM_H:   ld_data = {{48{ld_shift[15]}}, ld_shift[15:0]};
      MEM_W:   ld_data = {{32{ld_shift[31]}}, ld_shift[31:0]};
      MEM_D:   ld_data = ld_shift;
      MEM_BU:  ld_data = {56'b0, ld_shift[7:0]};
      MEM_HU:  ld_data = {48'b0, ld_shift[15:0]};
      MEM_WU:  ld_data = {32'b0, ld_shift[31:0]};
      default: ld_data = ld_shift;  // 111 behaves as LD
    endcase
  end

  always_comb begin
    base_mask = 8'h00;
    case (MemOp[1:0])
      2'b00:   base_mask = 8'h01;
      2'b01:   base_mask = 8'h03;
      2'b10:   base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  end

  assign mem_wmask = MemWen ? (base_mask << byte_off) : 8'h00;
  assign mem_wdata = rs2_val << {byte_off, 3'b000};

  // Writeback
  assign rf_wdata_d = MemToReg ? ld_data : alu_res;

endmodule

// File: tb/tb_ysyx_220053_exu.sv
module tb_ysyx_220053_exu;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd, rs1, rs2;
  logic        wen, ALUSrcA, MemToReg, MemWen;
  logic [1:0]  ALUSrcB, MulOp;
  logic [4:0]  ALUOp;
  logic [2:0]  Branch, MemOp;
  logic [63:0] pc, imm, mem_rdata;
  logic [63:0] dnpc, mem_addr, mem_wdata;
  logic        mem_ren, mem_wen;
  logic [7:0]  mem_wmask;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] SENT = 64'h5A5A_5A5A_5A5A_5A5A;

  always #5 clk = ~clk;

  ysyx_220053_exu dut (
    .clk(clk), .rst(rst), .rd(rd), .rs1(rs1), .rs2(rs2), .wen(wen),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .Branch(Branch),
    .MemOp(MemOp), .MemToReg(MemToReg), .MemWen(MemWen), .MulOp(MulOp),
    .pc(pc), .imm(imm), .dnpc(dnpc), .mem_addr(mem_addr), .mem_ren(mem_ren),
    .mem_rdata(mem_rdata), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask)
  );

  task automatic clear_ctrl();
    rd = 0; rs1 = 0; rs2 = 0; wen = 0; ALUSrcA = 0; ALUSrcB = 2'b00;
    ALUOp = 5'd0; Branch = 3'b000; MemOp = 3'b000; MemToReg = 0; MemWen = 0;
    MulOp = 2'b00; pc = 0; imm = 0; mem_rdata = 0;
  endtask

  // Writes val into x[idx] via COPYB of the immediate.
  task automatic set_reg(input logic [4:0] idx, input logic [63:0] val);
    @(negedge clk);
    clear_ctrl();
    rd = idx; wen = 1; ALUSrcB = 2'b01; ALUOp = 5'd10; imm = val;
    @(posedge clk);
    #1 wen = 0;
  endtask

  // Observes x[idx] on mem_wdata with a zero byte offset (pc=0, B=0, ADD).
  task automatic read_reg(input logic [4:0] idx, output logic [63:0] val);
    clear_ctrl();
    rs2 = idx; ALUSrcA = 1; ALUSrcB = 2'b11;
    #1 val = mem_wdata;
  endtask

  // x12 = ALU(a, b) with operands from x10/x11; x12 preset to a sentinel.
  task automatic run_alu(input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] op, input logic w,
                         output logic [63:0] res);
    set_reg(10, a);
    set_reg(11, b);
    set_reg(12, SENT);
    @(negedge clk);
    clear_ctrl();
    rs1 = 10; rs2 = 11; ALUOp = op; MulOp = {1'b0, w}; rd = 12; wen = 1;
    @(posedge clk);
    #1 wen = 0;
    read_reg(12, res);
  endtask

  task automatic test_reset();
    logic [63:0] v;
    clear_ctrl();
    rst = 1;
    // Store and register write requested while reset is held.
    MemWen = 1; rd = 3; wen = 1; ALUSrcB = 2'b01; ALUOp = 5'd10; imm = 64'h55;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mem_wen !== 1'b0) begin
      failures++; $display("FAIL reset_mem_wen got=%b want=0", mem_wen);
    end
    @(negedge clk);
    rst = 0;
    MemWen = 0; wen = 0;
    read_reg(3, v);
    checks++;
    if (v !== 64'h0) begin
      failures++; $display("FAIL reset_no_write x3 got=%h want=0", v);
    end
    read_reg(5, v);
    checks++;
    if (v !== 64'h0) begin
      failures++; $display("FAIL reset_x5_rs2 got=%h want=0", v);
    end
    clear_ctrl();
    rs1 = 5; imm = 64'h100; Branch = 3'b010;
    #1;
    checks++;
    if (dnpc !== 64'h100) begin
      failures++; $display("FAIL reset_x5_rs1_jalr got=%h want=100", dnpc);
    end
    MemWen = 1;
    #1;
    checks++;
    if (mem_wen !== 1'b1) begin
      failures++; $display("FAIL mem_wen_after_reset got=%b want=1", mem_wen);
    end
    set_reg(0, 64'd7);
    read_reg(0, v);
    checks++;
    if (v !== 64'h0) begin
      failures++; $display("FAIL x0_write got=%h want=0", v);
    end
  endtask

  task automatic test_alu();
    logic [63:0] v;
    // ADDI x1 = x0 + -1
    @(negedge clk);
    clear_ctrl();
    rd = 1; wen = 1; ALUSrcB = 2'b01; imm = '1;
    @(posedge clk);
    #1 wen = 0;
    read_reg(1, v);
    checks++;
    if (v !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      failures++; $display("FAIL addi_x1 got=%h want=ffffffffffffffff", v);
    end
    // ADDI x1 = x1 + 0x10 while JALR-observing x1: old value before the edge.
    @(negedge clk);
    clear_ctrl();
    rs1 = 1; rd = 1; wen = 1; ALUSrcB = 2'b01; imm = 64'h10; Branch = 3'b010;
    #1;
    checks++;
    if (dnpc !== 64'hE) begin
      failures++; $display("FAIL read_old_value got=%h want=e", dnpc);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dnpc !== 64'h1E) begin
      failures++; $display("FAIL read_new_value got=%h want=1e", dnpc);
    end
    wen = 0;
    run_alu('1, 64'd1, 5'd0, 1'b1, v);
    checks++;
    if (v !== 64'h0) begin
      failures++; $display("FAIL addw got=%h want=0", v);
    end
    run_alu(64'h8000_0000, 64'd4, 5'd7, 1'b1, v);
    checks++;
    if (v !== 64'hFFFF_FFFF_F800_0000) begin
      failures++; $display("FAIL sraw got=%h want=fffffffff8000000", v);
    end
    run_alu(64'h8000_0000, 64'd4, 5'd6, 1'b0, v);
    checks++;
    if (v !== 64'h0000_0000_0800_0000) begin
      failures++; $display("FAIL srl got=%h want=0000000008000000", v);
    end
    run_alu(64'd5, 64'd7, 5'd1, 1'b0, v);
    checks++;
    if (v !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      failures++; $display("FAIL sub got=%h want=fffffffffffffffe", v);
    end
    run_alu('1, 64'd1, 5'd3, 1'b0, v);
    checks++;
    if (v !== 64'd1) begin
      failures++; $display("FAIL slt got=%h want=1", v);
    end
    run_alu('1, 64'd1, 5'd4, 1'b0, v);
    checks++;
    if (v !== 64'd0) begin
      failures++; $display("FAIL sltu got=%h want=0", v);
    end
    run_alu(64'd1, 64'd31, 5'd2, 1'b1, v);
    checks++;
    if (v !== 64'hFFFF_FFFF_8000_0000) begin
      failures++; $display("FAIL sllw got=%h want=ffffffff80000000", v);
    end
    run_alu(64'hFF00, 64'h0FF0, 5'd9, 1'b0, v);
    checks++;
    if (v !== 64'h0F00) begin
      failures++; $display("FAIL and got=%h want=f00", v);
    end
    run_alu(64'd3, 64'd4, 5'd20, 1'b0, v);
    checks++;
    if (v !== 64'd0) begin
      failures++; $display("FAIL undefined_op got=%h want=0", v);
    end
  endtask

  task automatic test_branch();
    set_reg(6, 64'h8000_0101);
    @(negedge clk);
    clear_ctrl();
    rs1 = 6; rs2 = 6; ALUOp = 5'd1; Branch = 3'b011;
    pc = 64'h8000_0000; imm = 64'h10;
    #1;
    checks++;
    if (dnpc !== 64'h8000_0010) begin
      failures++; $display("FAIL beq_taken got=%h want=80000010", dnpc);
    end
    rs2 = 0;
    #1;
    checks++;
    if (dnpc !== 64'h8000_0004) begin
      failures++; $display("FAIL beq_not_taken got=%h want=80000004", dnpc);
    end
    Branch = 3'b100;
    #1;
    checks++;
    if (dnpc !== 64'h8000_0010) begin
      failures++; $display("FAIL bne_taken got=%h want=80000010", dnpc);
    end
    Branch = 3'b001; imm = 64'hFFFF_FFFF_FFFF_FFF0;
    #1;
    checks++;
    if (dnpc !== 64'h7FFF_FFF0) begin
      failures++; $display("FAIL jal got=%h want=7ffffff0", dnpc);
    end
    Branch = 3'b010; imm = 64'd2;
    #1;
    checks++;
    if (dnpc !== 64'h8000_0102) begin
      failures++; $display("FAIL jalr got=%h want=80000102", dnpc);
    end
    Branch = 3'b111;
    #1;
    checks++;
    if (dnpc !== 64'h8000_0004) begin
      failures++; $display("FAIL branch_111 got=%h want=80000004", dnpc);
    end
  endtask

  // Load into x9 (preset to a sentinel) from x7 + off.
  task automatic do_load(input logic [63:0] off, input logic [2:0] op,
                         input logic [63:0] rdata, output logic [63:0] v);
    set_reg(9, SENT);
    @(negedge clk);
    clear_ctrl();
    rs1 = 7; imm = off; ALUSrcB = 2'b01; MemToReg = 1; MemOp = op;
    mem_rdata = rdata; rd = 9; wen = 1;
    @(posedge clk);
    #1 wen = 0;
    read_reg(9, v);
  endtask

  task automatic test_mem();
    logic [63:0] v;
    set_reg(7, 64'h8000_0000);
    set_reg(8, 64'hAB);
    @(negedge clk);
    clear_ctrl();
    rs1 = 7; rs2 = 8; imm = 64'd3; ALUSrcB = 2'b01; MemWen = 1; MemOp = 3'b000;
    #1;
    checks++;
    if (mem_addr !== 64'h8000_0000) begin
      failures++; $display("FAIL sb_addr got=%h want=80000000", mem_addr);
    end
    checks++;
    if (mem_wmask !== 8'h08) begin
      failures++; $display("FAIL sb_wmask got=%h want=08", mem_wmask);
    end
    checks++;
    if (mem_wdata !== 64'hAB00_0000) begin
      failures++; $display("FAIL sb_wdata got=%h want=ab000000", mem_wdata);
    end
    checks++;
    if (mem_ren !== 1'b0 || mem_wen !== 1'b1) begin
      failures++; $display("FAIL sb_strobes got ren=%b wen=%b want ren=0 wen=1", mem_ren, mem_wen);
    end
    imm = 64'd6; MemOp = 3'b010;
    #1;
    checks++;
    if (mem_wmask !== 8'hC0 || mem_wdata !== 64'h00AB_0000_0000_0000) begin
      failures++; $display("FAIL sw_cross got mask=%h data=%h want mask=c0 data=00ab000000000000", mem_wmask, mem_wdata);
    end
    MemWen = 0;
    #1;
    checks++;
    if (mem_wmask !== 8'h00) begin
      failures++; $display("FAIL no_store_mask got=%h want=00", mem_wmask);
    end
    MemToReg = 1;
    #1;
    checks++;
    if (mem_ren !== 1'b1) begin
      failures++; $display("FAIL load_ren got=%b want=1", mem_ren);
    end
    do_load(64'd3, 3'b000, 64'hAB00_0000, v);
    checks++;
    if (v !== 64'hFFFF_FFFF_FFFF_FFAB) begin
      failures++; $display("FAIL lb got=%h want=ffffffffffffffab", v);
    end
    do_load(64'd3, 3'b100, 64'hAB00_0000, v);
    checks++;
    if (v !== 64'hAB) begin
      failures++; $display("FAIL lbu got=%h want=ab", v);
    end
    do_load(64'd6, 3'b001, 64'h8001_0000_0000_0000, v);
    checks++;
    if (v !== 64'hFFFF_FFFF_FFFF_8001) begin
      failures++; $display("FAIL lh got=%h want=ffffffffffff8001", v);
    end
    do_load(64'd4, 3'b010, 64'h8765_4321_0000_0000, v);
    checks++;
    if (v !== 64'hFFFF_FFFF_8765_4321) begin
      failures++; $display("FAIL lw got=%h want=ffffffff87654321", v);
    end
    do_load(64'd4, 3'b110, 64'h8765_4321_0000_0000, v);
    checks++;
    if (v !== 64'h8765_4321) begin
      failures++; $display("FAIL lwu got=%h want=87654321", v);
    end
    do_load(64'd0, 3'b111, 64'h0123_4567_89AB_CDEF, v);
    checks++;
    if (v !== 64'h0123_4567_89AB_CDEF) begin
      failures++; $display("FAIL ld_111 got=%h want=0123456789abcdef", v);
    end
    do_load(64'd5, 3'b011, 64'h1122_3344_5566_7788, v);
    checks++;
    if (v !== 64'h11_2233) begin
      failures++; $display("FAIL ld_cross got=%h want=112233", v);
    end
  endtask

  task automatic test_mext();
    logic [63:0] v;
    logic [63:0] e_div0, e_rem0, e_ovf, e_mulhu, e_divw, e_remu;
`ifdef YSYX_220053_RV64M_EN
    e_div0 = '1; e_rem0 = 64'd7; e_ovf = 64'h8000_0000_0000_0000;
    e_mulhu = 64'hFFFF_FFFF_FFFF_FFFE; e_divw = 64'hFFFF_FFFF_FFFF_FFFD;
    e_remu = 64'd1;
`else
    e_div0 = 0; e_rem0 = 0; e_ovf = 0; e_mulhu = 0; e_divw = 0; e_remu = 0;
`endif
    run_alu(64'd7, 64'd0, 5'd15, 1'b0, v);
    checks++;
    if (v !== e_div0) begin
      failures++; $display("FAIL div_by_zero got=%h want=%h", v, e_div0);
    end
    run_alu(64'd7, 64'd0, 5'd17, 1'b0, v);
    checks++;
    if (v !== e_rem0) begin
      failures++; $display("FAIL rem_by_zero got=%h want=%h", v, e_rem0);
    end
    run_alu(64'h8000_0000_0000_0000, '1, 5'd15, 1'b0, v);
    checks++;
    if (v !== e_ovf) begin
      failures++; $display("FAIL div_overflow got=%h want=%h", v, e_ovf);
    end
    run_alu('1, '1, 5'd14, 1'b0, v);
    checks++;
    if (v !== e_mulhu) begin
      failures++; $display("FAIL mulhu got=%h want=%h", v, e_mulhu);
    end
    run_alu(64'h0000_0000_FFFF_FFF9, 64'd2, 5'd15, 1'b1, v);
    checks++;
    if (v !== e_divw) begin
      failures++; $display("FAIL divw got=%h want=%h", v, e_divw);
    end
    run_alu(64'd7, 64'd3, 5'd18, 1'b0, v);
    checks++;
    if (v !== e_remu) begin
      failures++; $display("FAIL remu got=%h want=%h", v, e_remu);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] v;
    set_reg(4, 64'h1234);
    read_reg(4, v);
    checks++;
    if (v !== 64'h1234) begin
      failures++; $display("FAIL pre_async_reset got=%h want=1234", v);
    end
    // Assert reset mid-cycle, away from any clock edge.
    #1 rst = 1;
    read_reg(4, v);
    checks++;
    if (v !== 64'h0) begin
      failures++; $display("FAIL async_reset_clear got=%h want=0", v);
    end
    #1 rst = 0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_mem();
    test_mext();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
